alu_control_seq: RTL and testbench

Parametrised successor to the single-cycle ALU control decoder in the datapath.
- Decodes ALUOp/Func into the 4-bit ALU select, exactly as the existing single-cycle decoder does.
- Adds an iterative unsigned multiply/divide engine for the MUL and DIV R-type ops, with a stall handshake to the pipeline/hazard unit.
- Single-cycle ops pass through with zero added latency. MUL/DIV hold the pipeline until a result is produced.

---
 rtl/alu_control_seq_if.sv | 28 ++
 rtl/alu_control_seq.sv | 172 +++++++++++++++++
 tb/tb_alu_control_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alu_control_seq_if.sv
// Pipeline <-> ALU-control bundle: EX-stage decode inputs, stall handshake and
// the multi-cycle MUL/DIV result bus.
interface alu_control_seq_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic [2:0]       ALUOp;
  logic [5:0]       Func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       sel;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             result_valid;
  logic             div_by_zero;

  modport master (
    output valid_in, ALUOp, Func, a, b,
    input  sel, stall, busy, result, result_hi, result_valid, div_by_zero
  );

  modport slave (
    input  valid_in, ALUOp, Func, a, b,
    output sel, stall, busy, result, result_hi, result_valid, div_by_zero
  );
endinterface

// File: rtl/alu_control_seq.sv
// ALU select decoder with an iterative unsigned MUL/DIV engine that stalls the
// pipeline while an operation is in flight.
module alu_control_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  alu_control_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] SEL_MUL = 4'b0011;
  localparam logic [3:0] SEL_DIV = 4'b0100;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [3:0] sel_c;
  logic       is_multi, is_div;

  always_comb begin
    sel_c = 4'b1000;
    case (bus.ALUOp)
      3'b000: sel_c = 4'b0010;
      3'b001: sel_c = 4'b0110;
      3'b010: sel_c = 4'b0000;
      3'b011: sel_c = 4'b0001;
      3'b100: sel_c = 4'b0111;
      3'b101: begin
        case (bus.Func)
          6'b100000: sel_c = 4'b0010;
          6'b100100: sel_c = 4'b0000;
          6'b101010: sel_c = 4'b0111;
          6'b100010: sel_c = 4'b0110;
          6'b100101: sel_c = 4'b0001;
          6'b000000: sel_c = 4'b1000;
          6'b000010: sel_c = SEL_MUL;
          6'b011010: sel_c = SEL_DIV;
          default:   sel_c = 4'b0010;
        endcase
      end
      default: sel_c = 4'b1000;
    endcase
  end

  assign is_div   = (sel_c == SEL_DIV);
  assign is_multi = (sel_c == SEL_MUL) || is_div;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             div_q, div_d;
  // hi/lo: MUL accumulator/multiplier, DIV partial remainder/quotient
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
  logic             rv_q, rv_d, dbz_q, dbz_d, busy_q, busy_d;

  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    if (div_q) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_sh[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    div_d    = div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
    rv_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.valid_in && is_multi) begin
          div_d = is_div;
          dbz_d = 1'b0;
          cnt_d = '0;
          a_d   = bus.a;
          b_d   = bus.b;
          hi_d  = '0;
          lo_d  = is_div ? bus.a : bus.b;
          if (is_div && (bus.b == '0)) begin
            res_d    = '1;
            res_hi_d = bus.a;
            dbz_d    = 1'b1;
            rv_d     = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          res_d    = step_lo;
          res_hi_d = step_hi;
          rv_d     = 1'b1;
          state_d  = S_DONE;
        end
      end
      // DONE ignores valid_in so the held instruction is not re-issued
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      div_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      rv_q     <= 1'b0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      div_q    <= div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      rv_q     <= rv_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.sel          = sel_c;
  assign bus.stall        = ((state_q == S_IDLE) && bus.valid_in && is_multi) ||
                            (state_q == S_BUSY);
  assign bus.busy         = busy_q;
  assign bus.result       = res_q;
  assign bus.result_hi    = res_hi_q;
  assign bus.result_valid = rv_q;
  assign bus.div_by_zero  = dbz_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: decode table sweep plus MUL/DIV sequences checked
// through an expected-result queue popped on result_valid.
module tb_alu_control_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_control_seq_if #(.WIDTH(W)) bus ();
  alu_control_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
    int           due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic       vld;
    logic [2:0] op;
    logic [5:0] fn;
    logic [3:0] sel;
  } dec_t;
  dec_t dv[17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.result_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_result_valid", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("result", bus.result, mon_e.lo);
        chk("result_hi", bus.result_hi, mon_e.hi);
        chk("div_by_zero", bus.div_by_zero, mon_e.dbz);
        chk("result_valid_cycle", cyc, mon_e.due);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
    end
  endtask

  // Issue one MUL/DIV and hold valid_in until stall drops (the DONE cycle)
  task automatic run_op(input logic is_div, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] elo, input logic [W-1:0] ehi, input logic edbz,
                        input bit scramble, input bit chk_dbz_clr);
    exp_t e;
    int   n, exp_stall;
    @(posedge clk); #1;
    bus.valid_in = 1'b1;
    bus.ALUOp    = 3'b101;
    bus.Func     = is_div ? 6'b011010 : 6'b000010;
    bus.a        = av;
    bus.b        = bv;
    exp_stall = edbz ? 1 : W + 1;
    e.lo = elo; e.hi = ehi; e.dbz = edbz; e.due = cyc + exp_stall;
    sb.push_back(e);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.stall) break;
      n++;
      if (n == 2 && chk_dbz_clr) chk("dbz_cleared_on_accept", bus.div_by_zero, 0);
      if (n == 2) chk("busy_in_busy", bus.busy, 1);
      if (scramble && n >= 2) begin
        bus.a = $urandom;
        bus.b = $urandom;
      end
    end
    chk("stall_cycles", n, exp_stall);
    chk("busy_in_done", bus.busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    dv[0]  = '{1'b1, 3'b000, 6'b000000, 4'b0010};
    dv[1]  = '{1'b1, 3'b001, 6'b000000, 4'b0110};
    dv[2]  = '{1'b1, 3'b010, 6'b000000, 4'b0000};
    dv[3]  = '{1'b1, 3'b011, 6'b000000, 4'b0001};
    dv[4]  = '{1'b1, 3'b100, 6'b000000, 4'b0111};
    dv[5]  = '{1'b1, 3'b101, 6'b100000, 4'b0010};
    dv[6]  = '{1'b1, 3'b101, 6'b100100, 4'b0000};
    dv[7]  = '{1'b1, 3'b101, 6'b101010, 4'b0111};
    dv[8]  = '{1'b1, 3'b101, 6'b100010, 4'b0110};
    dv[9]  = '{1'b1, 3'b101, 6'b100101, 4'b0001};
    dv[10] = '{1'b1, 3'b101, 6'b000000, 4'b1000};
    dv[11] = '{1'b0, 3'b101, 6'b000010, 4'b0011};
    dv[12] = '{1'b0, 3'b101, 6'b011010, 4'b0100};
    dv[13] = '{1'b1, 3'b101, 6'b111111, 4'b0010};
    dv[14] = '{1'b1, 3'b110, 6'b000000, 4'b1000};
    dv[15] = '{1'b1, 3'b111, 6'b011010, 4'b1000};
    dv[16] = '{1'b1, 3'b000, 6'b000010, 4'b0010};

    rst = 1'b1;
    bus.valid_in = 1'b0;
    bus.ALUOp = 3'b000;
    bus.Func = 6'b000000;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_result_hi", bus.result_hi, 0);
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_div_by_zero", bus.div_by_zero, 0);
    chk("rst_stall", bus.stall, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      bus.valid_in = dv[i].vld;
      bus.ALUOp    = dv[i].op;
      bus.Func     = dv[i].fn;
      bus.a        = $urandom;
      bus.b        = $urandom;
      @(negedge clk);
      chk($sformatf("sel_%0d", i), bus.sel, dv[i].sel);
      chk($sformatf("stall_%0d", i), bus.stall, 0);
    end
    idle(2);
    chk("decode_no_busy", bus.busy, 0);

    run_op(1'b0, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0, 1'b0, 1'b0);
    idle(3);
    @(negedge clk);
    chk("mul_busy_after", bus.busy, 0);
    chk("result_hold", bus.result, 42);

    run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'h1, 1'b0, 1'b1, 1'b0);
    idle(2);
    run_op(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 1'b0);
    idle(1);
    run_op(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Reset in the middle of a MUL: the op is dropped with no result
    @(posedge clk); #1;
    bus.valid_in = 1'b1;
    bus.ALUOp = 3'b101;
    bus.Func = 6'b000010;
    bus.a = 32'd5;
    bus.b = 32'd5;
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_stall", bus.stall, 0);
    chk("midrst_result", bus.result, 0);
    chk("midrst_result_valid", bus.result_valid, 0);
    run_op(1'b0, 32'd3, 32'd3, 32'd9, 32'd0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: DIV held through DONE, MUL presented the next cycle
    idle(1);
    run_op(1'b1, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 32'h1234_5678, 32'h10, 32'h2345_6780, 32'h1, 1'b0, 1'b0, 1'b0);
    idle(5);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
